cmp1_response_checker: RTL
==========================

Name: cmp1_response_checker

Overview:
- Synthesizable response checker for the 1-bit magnitude comparator: o1 = A<B (~A&B), o2 = A==B (XNOR), o3 = A>B (A&~B).
- Sits opposite the stimulus side. The stimulus side applies {A,B} and strobes vec_valid. This block waits for the outputs to settle, compares them against golden values, and reports pass/fail counts, first-failure capture and input-space coverage.
- Used on-board (FPGA self-test) and in simulation in place of waveform inspection.

Parameters:
- SETTLE_CYC, 2, clock cycles between vec_valid acceptance and sampling of o1..o3 (legal range 1..15).
- CNT_W, 8, width of the vector and fail counters (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- vec_valid  input  1  stimulus {A,B} is applied and stable this cycle.
- vec_ready  output  1  checker idle and able to accept a vector.
- A  input  1  applied comparator input A.
- B  input  1  applied comparator input B.
- o1  input  1  DUT less-than output.
- o2  input  1  DUT equal output.
- o3  input  1  DUT greater-than output.
- end_test  input  1  stimulus side finished; freeze results.
- vec_cnt  output  CNT_W  vectors checked.
- fail_cnt  output  CNT_W  vectors that mismatched.
- err  output  1  sticky, set on any mismatch.
- first_fail  output  5  {A,B,o1,o2,o3} of the first failing vector.
- cov  output  4  bit {A,B} set once that input combination has been checked.
- all_cov  output  1  cov == 4'b1111.
- done  output  1  results frozen.

Behaviour:
- Reset values:
  - vec_ready=1; vec_cnt=0; fail_cnt=0; err=0; first_fail=0; cov=0; all_cov=0; done=0.
  - FSM=IDLE; settle counter=0.
  - rst overrides everything, including mid-SETTLE and DONE.
- Handshake: a vector is accepted on a cycle where vec_valid && vec_ready. {A,B} are registered on acceptance. vec_ready=1 only in IDLE.
- FSM states:
  - IDLE: on accept, latch {A,B}, clear the settle counter, go to SETTLE. If end_test is high (with or without vec_valid), go to DONE; end_test takes priority and the vector is not accepted.
  - SETTLE: increment the counter each cycle. When counter == SETTLE_CYC-1, go to CHECK. The live A/B inputs are ignored in this state; the latched values are used.
  - CHECK (one cycle):
    - Compute expected {lt,eq,gt} from the latched A,B and compare to the sampled {o1,o2,o3}.
    - Increment vec_cnt (saturate at all-ones). Set cov[{A,B}].
    - On mismatch: increment fail_cnt (saturating) and set err. If err was 0 before this cycle, load first_fail.
    - Return to IDLE.
  - DONE: done=1, vec_ready=0. All result outputs hold. Exit only via rst.
- Latency: 1 cycle accept→SETTLE, SETTLE_CYC cycles in SETTLE, counters updated at the CHECK edge. vec_ready returns SETTLE_CYC+2 cycles after acceptance.
- Illegal DUT codes (e.g. o1&o3, or all zero) are ordinary mismatches.
- end_test asserted during SETTLE/CHECK is ignored. It must be held until done=1, or re-asserted in IDLE.
- all_cov is registered and equals &cov from the cycle after the final cov update.

Decomposition:
- Shared package cmp1_pkg:
  - state enum (IDLE, SETTLE, CHECK, DONE);
  - localparam function for the expected triple {~a&b, ~(a^b), a&~b};
  - FAIL_REC_W=5.
- One natural sub-module: sat_counter (parameter W; inc, clr; saturating). Instantiated twice, for vec_cnt and fail_cnt.

Test Plan:
- Correct DUT model, vectors 00,01,10,11 each with vec_valid for 1 cycle, then end_test → vec_cnt=4, fail_cnt=0, err=0, cov=4'b1111, all_cov=1, done=1.
- Fault DUT with o2 stuck at 0, vectors 00,01,10,11 → fail_cnt=2, err=1, first_fail=5'b00000, cov=4'b1111.
- rst pulse while in SETTLE after accepting 11 → vec_cnt=0, cov=0, vec_ready=1 the next cycle. A following vector 10 gives vec_cnt=1, cov=4'b0100.
- vec_valid held high continuously with SETTLE_CYC=2 → one acceptance every 4 cycles. A/B toggled during SETTLE does not alter the checked vector.
- CNT_W=2, six correct vectors → vec_cnt saturates at 3 and fail_cnt stays 0.
- end_test and vec_valid asserted together in IDLE → vector not counted, done=1 next cycle. Further vec_valid is ignored and vec_ready stays 0.

Source files
------------

// File: rtl/cmp1_pkg.sv
// Shared types and golden reference for the 1-bit comparator response checker.
// Holds the checker state encoding, failure-record width and expected-output function.
package cmp1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int FAIL_REC_W = 5;

    // Golden {lt, eq, gt} for a 1-bit magnitude compare of a against b.
    function automatic logic [2:0] exp_triple(input logic a, input logic b);
        return {~a & b, ~(a ^ b), a & ~b};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: count visible one cycle after inc; clr is synchronous and wins over inc.
// Backpressure: none, inc is sampled every cycle.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cmp1_response_checker.sv
// Checks a 1-bit comparator's {lt,eq,gt} against golden values; counts, records first failure, tracks coverage.
// Latency: accept -> SETTLE_CYC settle cycles -> one CHECK cycle; vec_ready returns SETTLE_CYC+2 cycles after accept.
// Backpressure: vec_ready is high only in IDLE; once end_test is seen, results freeze and vec_ready stays low until rst.
module cmp1_response_checker
    import cmp1_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic                  A,
    input  logic                  B,
    input  logic                  o1,
    input  logic                  o2,
    input  logic                  o3,
    input  logic                  end_test,
    output logic [CNT_W-1:0]      vec_cnt,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic                  err,
    output logic [FAIL_REC_W-1:0] first_fail,
    output logic [3:0]            cov,
    output logic                  all_cov,
    output logic                  done
);

    localparam int            SET_W       = 4;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    state_e                  state_q, state_d;
    logic [SET_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              ab_q, ab_d;
    logic                    err_q, err_d;
    logic [FAIL_REC_W-1:0]   first_fail_q, first_fail_d;
    logic [3:0]              cov_q, cov_d;
    logic                    all_cov_q, all_cov_d;
    logic                    vec_inc;
    logic                    fail_inc;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ab_d         = ab_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        cov_d        = cov_q;
        all_cov_d    = &cov_q;
        vec_inc      = 1'b0;
        fail_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // end_test wins over a coincident vector, which is then dropped.
                if (end_test) begin
                    state_d = ST_DONE;
                end else if (vec_valid) begin
                    ab_d    = {A, B};
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                vec_inc      = 1'b1;
                cov_d[ab_q]  = 1'b1;
                if (exp_triple(ab_q[1], ab_q[0]) != {o1, o2, o3}) begin
                    fail_inc = 1'b1;
                    err_d    = 1'b1;
                    if (!err_q) begin
                        first_fail_d = {ab_q, o1, o2, o3};
                    end
                end
                state_d = ST_IDLE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ab_q         <= '0;
            err_q        <= 1'b0;
            first_fail_q <= '0;
            cov_q        <= '0;
            all_cov_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ab_q         <= ab_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            cov_q        <= cov_d;
            all_cov_q    <= all_cov_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk (clk),
        .clr (rst),
        .inc (vec_inc),
        .cnt (vec_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .clr (rst),
        .inc (fail_inc),
        .cnt (fail_cnt)
    );

    assign vec_ready  = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign first_fail = first_fail_q;
    assign cov        = cov_q;
    assign all_cov    = all_cov_q;

endmodule
